if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch front end of the ARM pipeline. It owns the program counter and drives a request/ready instruction-memory port. Each cycle it presents `pc_out` and `instruction_out` to the IF/ID pipeline register, and it obeys the same `freeze` and branch-flush controls that register uses. Memory wait states and hazard freezes are absorbed internally: the downstream register sees either a valid instruction or a zero bubble, and never a duplicated or lost fetch.

## Interface
Parameters:
- `WORD_WIDTH`, default `` `WORD_WIDTH `` (32) — data, address and PC width.
- `RESET_PC`, default 0 — PC value loaded on reset.

Ports:
- `clk` in 1 — the single clock; all state updates on its rising edge.
- `rst` in 1 — reset, synchronous, active-high.
- `freeze` in 1 — hazard stall; the IF/ID register holds its contents.
- `branch_taken` in 1 — redirect from EX; also flushes the IF/ID register.
- `branch_addr` in WORD_WIDTH — redirect target.
- `imem_req` out 1 — fetch request valid.
- `imem_addr` out WORD_WIDTH — fetch address, equal to the current PC.
- `imem_ready` in 1 — `imem_rdata` is valid this cycle; may assert in the same cycle as the request.
- `imem_rdata` in WORD_WIDTH — fetched instruction word.
- `pc_out` out WORD_WIDTH — PC+4 of the presented instruction, or 0 when a bubble is presented.
- `instruction_out` out WORD_WIDTH — presented instruction, or 0 (bubble).

## Operation
- State: `pc` register, hold buffer (`hold_instr`, `hold_pc4`), two-state FSM {FETCH, HOLD}.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - `imem_ready`=1 and `freeze`=0: present `imem_rdata` with `pc_out`=`pc`+4, then `pc`←`pc`+4; stay in FETCH.
  - `imem_ready`=1 and `freeze`=1: capture `imem_rdata` and `pc`+4 into the hold buffer, then `pc`←`pc`+4 → HOLD.
  - `imem_ready`=0: present a bubble; `pc` unchanged.
- HOLD:
  - `imem_req`=0.
  - Present the hold buffer on the outputs.
  - `freeze`=0 → FETCH. The held instruction is consumed this cycle.
- `branch_taken`=1 in any state, with priority over `freeze` and `imem_ready`:
  - `pc`←`branch_addr`; hold buffer invalidated; go to FETCH.
  - Outputs present a bubble.
  - `imem_req` stays as the state dictates, but any `imem_rdata` returned in that cycle is discarded.
- `rst`=1 has priority over everything: `pc`←`RESET_PC`, FSM→FETCH, hold buffer cleared.
- PC arithmetic is modulo 2^WORD_WIDTH; 0xFFFFFFFC+4 wraps to 0 silently.
- The low two bits of `branch_addr` pass through unmodified (alignment is the EX stage's responsibility).
- Outputs are combinational from state and the memory inputs. The only registered state is `pc`, the FSM and the hold buffer.

## Timing
- Reset values, in the cycle after `rst`: FSM=FETCH, `pc`=`RESET_PC`, `imem_req`=1, `imem_addr`=`RESET_PC`. `pc_out` and `instruction_out` are 0 unless `imem_ready`=1.
- Zero-wait memory (`imem_ready` tied 1): throughput is one instruction per cycle, with latency 0 from `imem_addr` to `instruction_out`.
- N wait cycles produce N bubble cycles; `imem_addr` is stable throughout.
- A freeze lasting F cycles beginning on a ready cycle:
  - Outputs hold the same word for F+1 cycles.
  - No memory request is issued during HOLD.
  - The next address is issued in the cycle after the freeze ends.
- A freeze during a wait: the FSM stays in FETCH; the response is captured on ready if still frozen.
- Branch: the target appears on `imem_addr` in the cycle after `branch_taken`.
- `rst` asserted mid-wait or mid-HOLD: the pending word is dropped and the next cycle is a reset fetch.

## Configuration
- `IF_FETCH_PERF_EN` defined:
  - Adds two outputs, `perf_fetch_cnt` and `perf_bubble_cnt`, each 32 bits.
  - Counters saturate at 0xFFFFFFFF and are cleared by `rst`.
  - `perf_fetch_cnt` counts cycles in which a non-bubble instruction is consumed.
  - `perf_bubble_cnt` counts bubble cycles that are not frozen.
- `IF_FETCH_PERF_EN` undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- `settings.h` holds `WORD_WIDTH`, the bubble encoding (`BUBBLE_INSTR`=0), the FSM state encodings `IF_FETCH`/`IF_HOLD`, and the PC increment constant (4).
- One sub-module, `if_hold_buffer`: a single-entry capture/hold register with load, clear and valid.
- The PC register, FSM and output muxing stay in `if_fetch_unit`.

## Test plan
- Reset, then ready=1 continuously → `imem_addr`=0, 4, 8 on consecutive cycles; `pc_out`=4, 8, 12; `instruction_out` equals the memory word at each address.
- ready=0 for 2 cycles at addr 0x8 → two cycles with `pc_out`=0 and `instruction_out`=0; `imem_addr` held at 0x8; the third cycle presents word@0x8 with `pc_out`=0xC.
- At addr 0xC, rdata=0xE3A01005, freeze=1 for 3 cycles → HOLD; `instruction_out`=0xE3A01005 and `pc_out`=0x10 for 4 cycles; `imem_req`=0 for 3 cycles; the next request is to 0x10.
- In HOLD with freeze=1, pulse branch_taken with `branch_addr`=0x40 → outputs 0 that cycle; next cycle `imem_addr`=0x40; the held word is never re-presented.
- Assert rst while waiting at 0x20 with ready=0 → next cycle `imem_addr`=`RESET_PC`, and a late ready does not produce the 0x20 word.
- With `IF_FETCH_PERF_EN`: 5 fetches and 2 wait cycles → `perf_fetch_cnt`=5 and `perf_bubble_cnt`=2; rst clears both.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared widths, bubble encoding, PC step and fetch FSM states
package if_fetch_unit_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int BUBBLE_INSTR = 0;
  localparam int PC_INC = 4;
  typedef enum logic {IF_FETCH, IF_HOLD} if_state_t;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: request/ready instruction-memory port
interface if_fetch_unit_if #(parameter int WORD_WIDTH = if_fetch_unit_pkg::WORD_WIDTH);
  logic req;
  logic [WORD_WIDTH-1:0] addr;
  logic ready;
  logic [WORD_WIDTH-1:0] rdata;
  modport master (output req, addr, input ready, rdata);
  modport slave (input req, addr, output ready, rdata);
endinterface

// File: rtl/if_fetch_unit_hold_buffer.sv
// if_hold_buffer: single-entry capture/hold register for a word frozen on arrival
module if_hold_buffer #(
  parameter int WORD_WIDTH = if_fetch_unit_pkg::WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [WORD_WIDTH-1:0] d_instr,
  input  logic [WORD_WIDTH-1:0] d_pc4,
  output logic                  valid,
  output logic [WORD_WIDTH-1:0] instr,
  output logic [WORD_WIDTH-1:0] pc4
);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      instr <= '0;
      pc4 <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= d_instr;
      pc4 <= d_pc4;
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC, fetch FSM and IF/ID output mux; IF_FETCH_PERF_EN adds perf counters
module if_fetch_unit #(
  parameter int WORD_WIDTH = if_fetch_unit_pkg::WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_addr,
  if_fetch_unit_if.master       imem,
  output logic [WORD_WIDTH-1:0] pc_out,
  output logic [WORD_WIDTH-1:0] instruction_out
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_bubble_cnt
`endif
);
  import if_fetch_unit_pkg::*;
  localparam logic [WORD_WIDTH-1:0] BUBBLE = WORD_WIDTH'(BUBBLE_INSTR);
  if_state_t state, state_nxt;
  logic [WORD_WIDTH-1:0] pc, pc_nxt, pc4, hold_instr, hold_pc4;
  logic fetch_ok, in_hold, load, clear, hold_valid, bubble, consumed;
  assign pc4 = pc + WORD_WIDTH'(PC_INC);
  if_hold_buffer #(.WORD_WIDTH(WORD_WIDTH)) u_hold (
    .clk(clk), .rst(rst), .load(load), .clear(clear),
    .d_instr(imem.rdata), .d_pc4(pc4),
    .valid(hold_valid), .instr(hold_instr), .pc4(hold_pc4)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IF_FETCH;
      pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
    end
  end
  // A branch overrides everything: the returning word and any held word are dropped.
  always_comb begin
    in_hold = state == IF_HOLD;
    fetch_ok = !in_hold && imem.ready;
    imem.req = !in_hold;
    imem.addr = pc;
    load = fetch_ok && freeze && !branch_taken;
    clear = branch_taken || (in_hold && !freeze);
    state_nxt = branch_taken ? IF_FETCH : load ? IF_HOLD : (in_hold && !freeze) ? IF_FETCH : state;
    pc_nxt = branch_taken ? branch_addr : fetch_ok ? pc4 : pc;
    bubble = branch_taken || (!in_hold && !imem.ready) || (in_hold && !hold_valid);
    consumed = !bubble && !freeze;
    instruction_out = bubble ? BUBBLE : in_hold ? hold_instr : imem.rdata;
    pc_out = bubble ? '0 : in_hold ? hold_pc4 : pc4;
  end
`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + {31'b0, consumed && ~&perf_fetch_cnt};
      perf_bubble_cnt <= perf_bubble_cnt + {31'b0, bubble && !freeze && ~&perf_bubble_cnt};
    end
  end
`else
  logic unused_perf;
  assign unused_perf = consumed;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed stimulus with a scoreboard queue drained by a negedge monitor
module tb_if_fetch_unit;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic freeze = 1'b0;
  logic branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] pc_out, instruction_out;
  int checks = 0;
  int errors = 0;
  int step_n = 0;
  exp_t sb[$];
  if_fetch_unit_if #(.WORD_WIDTH(32)) imem ();
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif
  if_fetch_unit #(.WORD_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem(imem.master),
    .pc_out(pc_out), .instruction_out(instruction_out)
`ifdef IF_FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );
  always #5 clk = ~clk;
  always_comb imem.rdata = (imem.addr == 32'hC) ? 32'hE3A01005 : {16'hA5A5, imem.addr[15:0]};
  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step_n, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("imem_req", {31'b0, imem.req}, {31'b0, e.req});
      cmp("imem_addr", imem.addr, e.addr);
      cmp("pc_out", pc_out, e.pc);
      cmp("instruction_out", instruction_out, e.instr);
    end
  end
  task automatic cyc(input logic rs, input logic rd, input logic fz, input logic br,
                     input logic [31:0] ba, input logic chk, input logic er,
                     input logic [31:0] ea, input logic [31:0] ep, input logic [31:0] ei);
    @(posedge clk);
    #1;
    step_n++;
    rst = rs;
    imem.ready = rd;
    freeze = fz;
    branch_taken = br;
    branch_addr = ba;
    if (chk) sb.push_back('{req: er, addr: ea, pc: ep, instr: ei});
  endtask
  initial begin
    imem.ready = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0);
    cyc(0, 1, 0, 0, 0, 1, 1, 32'h0, 32'h4, 32'hA5A50000);
    cyc(0, 1, 0, 0, 0, 1, 1, 32'h4, 32'h8, 32'hA5A50004);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h8, 32'h0, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h8, 32'h0, 32'h0);
    cyc(0, 1, 0, 0, 0, 1, 1, 32'h8, 32'hC, 32'hA5A50008);
    cyc(0, 1, 1, 0, 0, 1, 1, 32'hC, 32'h10, 32'hE3A01005);
    cyc(0, 1, 1, 0, 0, 1, 0, 32'h10, 32'h10, 32'hE3A01005);
    cyc(0, 1, 1, 0, 0, 1, 0, 32'h10, 32'h10, 32'hE3A01005);
    cyc(0, 1, 0, 0, 0, 1, 0, 32'h10, 32'h10, 32'hE3A01005);
    cyc(0, 1, 0, 0, 0, 1, 1, 32'h10, 32'h14, 32'hA5A50010);
    cyc(0, 1, 1, 0, 0, 1, 1, 32'h14, 32'h18, 32'hA5A50014);
    cyc(0, 1, 1, 1, 32'h40, 1, 0, 32'h18, 32'h0, 32'h0);
    cyc(0, 0, 1, 0, 0, 1, 1, 32'h40, 32'h0, 32'h0);
    cyc(0, 1, 1, 0, 0, 1, 1, 32'h40, 32'h44, 32'hA5A50040);
    cyc(0, 0, 0, 0, 0, 1, 0, 32'h44, 32'h44, 32'hA5A50040);
    cyc(0, 1, 0, 1, 32'h20, 1, 1, 32'h44, 32'h0, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h20, 32'h0, 32'h0);
    cyc(1, 0, 0, 0, 0, 1, 1, 32'h20, 32'h0, 32'h0);
    cyc(0, 1, 0, 0, 0, 1, 1, 32'h0, 32'h4, 32'hA5A50000);
    cyc(0, 0, 0, 1, 32'hFFFFFFFC, 1, 1, 32'h4, 32'h0, 32'h0);
    cyc(0, 1, 0, 0, 0, 1, 1, 32'hFFFFFFFC, 32'h0, 32'hA5A5FFFC);
    cyc(0, 1, 0, 0, 0, 1, 1, 32'h0, 32'h4, 32'hA5A50000);
    cyc(0, 0, 0, 1, 32'h103, 1, 1, 32'h4, 32'h0, 32'h0);
    cyc(0, 1, 0, 0, 0, 1, 1, 32'h103, 32'h107, 32'hA5A50103);
    cyc(0, 1, 1, 0, 0, 1, 1, 32'h107, 32'h10B, 32'hA5A50107);
    cyc(1, 1, 1, 0, 0, 1, 0, 32'h10B, 32'h10B, 32'hA5A50107);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0);
    cyc(0, 1, 0, 0, 0, 1, 1, 32'h0, 32'h4, 32'hA5A50000);
    cyc(0, 1, 0, 0, 0, 1, 1, 32'h4, 32'h8, 32'hA5A50004);
    cyc(0, 1, 0, 0, 0, 1, 1, 32'h8, 32'hC, 32'hA5A50008);
    cyc(0, 1, 0, 0, 0, 1, 1, 32'hC, 32'h10, 32'hE3A01005);
    cyc(0, 1, 0, 0, 0, 1, 1, 32'h10, 32'h14, 32'hA5A50010);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h14, 32'h0, 32'h0);
`ifdef IF_FETCH_PERF_EN
    @(posedge clk);
    #1;
    cmp("perf_fetch_cnt", perf_fetch_cnt, 32'd5);
    cmp("perf_bubble_cnt", perf_bubble_cnt, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cmp("perf_fetch_cnt_rst", perf_fetch_cnt, 32'd0);
    cmp("perf_bubble_cnt_rst", perf_bubble_cnt, 32'd0);
`endif
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
